mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Parametrised data-memory access stage for the sequential RISC-V core; successor to the combinational address-validity check.
- Holds a word-organised data memory, checks each request for bounds, size-aware alignment and illegal opcode combinations, and answers over a valid/ready request and one-cycle response handshake with configurable latency.
- Performs byte/half/word/double little-endian lane steering and load sign/zero extension.
- Keeps a sticky fault record (address and cause) for the trap logic.

Parameters:
- DATA_W, 64, memory word width in bits (power of two, >= 32); BYTES = DATA_W/8.
- ADDR_W, 64, byte-address width.
- DEPTH, 1024, number of memory words; legal word index is 0..DEPTH-1.
- LATENCY, 2, cycles from accept to response (>= 1).
- STRICT_ALIGN, 1, 1 = fault on natural misalignment; 0 = only accesses crossing a word boundary fault.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (3 is illegal if DATA_W = 32).
- is_unsigned  in  1  zero-extend the load when set, sign-extend otherwise.
- address  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- rdata  out  DATA_W  extended load data; 0 for stores, faults and no-ops.
- invMemAddr  out  1  qualifies resp_valid: request faulted.
- fault_valid  out  1  sticky fault record present.
- fault_addr  out  ADDR_W  address of the first unhandled fault.
- fault_cause  out  3  [0] misaligned, [1] out of range, [2] MemRead and MemWrite both set.
- fault_clear  in  1  clears the sticky record.

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, rdata=0, invMemAddr=0, fault_valid=0, fault_addr=0, fault_cause=0. Memory contents are not reset.
- Reset asserted mid-operation aborts the transaction. A pending store is not committed and no response is issued.
- FSM states are IDLE, WAIT and RESP.
  - req_ready=1 only in IDLE. Accept happens on req_valid && req_ready; address, size, opcode, wdata and is_unsigned are registered.
  - Accept with a fault: go to RESP next cycle with invMemAddr=1, rdata=0. The fault response always has one-cycle latency.
  - Accept without a fault: load counter with LATENCY-1 and go to WAIT (LATENCY=1 goes straight to RESP). WAIT decrements the counter and moves to RESP when it reaches 0.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. With LATENCY=L, resp_valid rises L cycles after the accept edge.
  - The earliest next accept is the cycle after RESP, so at most one request is outstanding.
- Fault checks are evaluated only when MemRead || MemWrite:
  - Out of range: address / BYTES > DEPTH-1, using the full ADDR_W unsigned compare. Upper address bits are never truncated.
  - Misaligned with STRICT_ALIGN=1: address mod (1<<size) != 0.
  - Misaligned with STRICT_ALIGN=0: (address mod BYTES) + (1<<size) > BYTES.
  - Illegal opcode: MemRead && MemWrite. Cause bits accumulate, so every violated condition is flagged.
- No-op (neither MemRead nor MemWrite): follows the normal LATENCY path, responds with rdata=0 and invMemAddr=0, and touches nothing.
- Store: commits in the RESP cycle. Only byte lanes [address mod BYTES, +(1<<size)) of word address/BYTES are written. Faulting stores never modify memory.
- Load: the word is read in the RESP cycle, the lanes are shifted down and the result is extended per is_unsigned. Doubles are never extended.
- Sticky record: on a faulting accept with fault_valid=0, capture fault_addr and fault_cause and set fault_valid=1.
  - Later faults do not overwrite the record while fault_valid=1.
  - fault_clear clears the record. A fault_clear in the same cycle as a new faulting accept captures the new fault (the new fault wins).

Decomposition:
- Shared package mem_pkg holds the size encodings (SZ_B, SZ_H, SZ_W, SZ_D), the fault_cause bit indices and the FSM state encoding.
- One sub-module, mem_lane_align: combinational store byte-enable/shift generation and load extract/sign-extend, parametrised by DATA_W.

Test Plan:
- Store double 0x1122334455667788 at address 0x10, then load double at 0x10 with LATENCY=2: resp_valid rises 2 cycles after each accept; load rdata=0x1122334455667788; invMemAddr=0.
- Load byte at 0x17, signed and then unsigned, from the same word: rdata=0x0000000000000011 for both; load half at 0x10 signed returns 0x0000000000007788.
  - Storing byte 0xF0 at 0x11 then signed byte load at 0x11 returns 0xFFFFFFFFFFFFFFF0; other bytes of the word are unchanged.
- Load at address 8192 (word 1024): resp_valid with invMemAddr=1 one cycle after accept; fault_valid=1, fault_addr=8192, fault_cause=3'b010.
  - A second fault at 0x3 does not change the record. fault_clear clears it.
- Word store at 0x2 with STRICT_ALIGN=1 faults with cause 3'b001 and memory is unchanged. With STRICT_ALIGN=0 the same store succeeds; a word store at 0x6 faults.
- MemRead=MemWrite=1 at address 0x7FF8 faults with cause 3'b110. fault_clear asserted in the same accept cycle leaves fault_valid=1 holding the new fault.
- Reset pulse during WAIT of a store to 0x20: no resp_valid; a later load of 0x20 returns the pre-store contents; req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access stage.
// Size codes, fault cause bit positions and FSM states.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int FC_MIS = 0;
  localparam int FC_OOR = 1;
  localparam int FC_ILL = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for stores and
// lane extract plus sign/zero extension for loads.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] wmask,
  output logic [DATA_W-1:0] wshift,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] szmask;
  logic [DATA_W-1:0] raw;
  logic [OFF_W+2:0]  shamt;
  logic              sign;

  assign shamt = {offset, 3'b000};

  always_comb begin
    szmask = '0;
    sign   = 1'b0;
    unique case (size)
      SZ_B: szmask = DATA_W'(8'hFF);
      SZ_H: szmask = DATA_W'(16'hFFFF);
      SZ_W: szmask = DATA_W'(32'hFFFF_FFFF);
      SZ_D: szmask = DATA_W'(64'hFFFF_FFFF_FFFF_FFFF);
      default: szmask = '0;
    endcase
    raw = (rword >> shamt) & szmask;
    // doubles are returned as-is, never extended
    unique case (size)
      SZ_B: sign = raw[7];
      SZ_H: sign = raw[15];
      SZ_W: sign = raw[31];
      default: sign = 1'b0;
    endcase
    rdata  = (sign && !is_unsigned) ? (raw | ~szmask) : raw;
    wmask  = szmask << shamt;
    wshift = (wdata & szmask) << shamt;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: checked requests, fixed-latency
// responses, lane steering and a sticky fault record.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 64,
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 2,
  parameter int STRICT_ALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              invMemAddr,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [2:0]        fault_cause,
  input  logic              fault_clear
);

  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY+1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [OFF_W-1:0]   r_off;
  logic [1:0]         r_size;
  logic               r_rd;
  logic               r_wr;
  logic               r_uns;
  logic               r_fault;
  logic [DATA_W-1:0]  r_wdata;
  logic [2:0]         cause;
  logic               accept;
  int                 off_i;
  int                 nb_i;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  rword;
  logic [DATA_W-1:0]  wmask;
  logic [DATA_W-1:0]  wshift;
  logic [DATA_W-1:0]  rext;

  assign accept = req_valid && req_ready;

  always_comb begin
    cause = '0;
    off_i = int'(address[OFF_W-1:0]);
    nb_i  = 1 << size;
    if (MemRead || MemWrite) begin
      // full-width compare so high address bits cannot alias
      cause[FC_OOR] = (address >> OFF_W) > ADDR_W'(DEPTH-1);
      if (STRICT_ALIGN != 0)
        cause[FC_MIS] = (nb_i > BYTES) || ((off_i & (nb_i-1)) != 0);
      else
        cause[FC_MIS] = (off_i + nb_i) > BYTES;
      cause[FC_ILL] = MemRead && MemWrite;
    end
  end

  assign rword = mem[r_idx];

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size        (r_size),
    .offset      (r_off),
    .is_unsigned (r_uns),
    .wdata       (r_wdata),
    .rword       (rword),
    .wmask       (wmask),
    .wshift      (wshift),
    .rdata       (rext)
  );

  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && r_wr && !r_fault)
      mem[r_idx] <= (rword & ~wmask) | (wshift & wmask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      rdata       <= '0;
      invMemAddr  <= 1'b0;
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_uns       <= 1'b0;
      r_fault     <= 1'b0;
      r_wdata     <= '0;
    end else begin
      resp_valid <= 1'b0;
      rdata      <= '0;
      invMemAddr <= 1'b0;
      if (fault_clear)
        fault_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            r_idx     <= address[OFF_W +: IDX_W];
            r_off     <= address[OFF_W-1:0];
            r_size    <= size;
            r_rd      <= MemRead;
            r_wr      <= MemWrite;
            r_uns     <= is_unsigned;
            r_wdata   <= wdata;
            r_fault   <= |cause;
            req_ready <= 1'b0;
            if (|cause) begin
              state <= S_RESP;
              // a new fault beats a same-cycle clear
              if (!fault_valid || fault_clear) begin
                fault_valid <= 1'b1;
                fault_addr  <= address;
                fault_cause <= cause;
              end
            end else if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_W'(LATENCY-1);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= S_RESP;
        end
        S_RESP: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b1;
          invMemAddr <= r_fault;
          if (r_rd && !r_fault)
            rdata <= rext;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: strict/L=2 and
// relaxed/L=1 instances share one request bus.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        sel = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        is_unsigned = 1'b0;
  logic        fault_clear = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [63:0] address = '0;
  logic [63:0] wdata = '0;

  logic        rdy0, rv0, inv0, fv0;
  logic [63:0] rd0, fa0;
  logic [2:0]  fc0;
  logic        rdy1, rv1, inv1, fv1;
  logic [63:0] rd1, fa1;
  logic [2:0]  fc1;

  logic        s_rv, s_inv;
  logic [63:0] s_rd;

  int total = 0;
  int bad = 0;

  logic [63:0] q_rd[$];
  bit          q_inv[$];
  int          q_lat[$];

  always #5 clk = ~clk;

  assign s_rv  = sel ? rv1 : rv0;
  assign s_inv = sel ? inv1 : inv0;
  assign s_rd  = sel ? rd1 : rd0;

  mem_access_unit #(
    .LATENCY      (2),
    .STRICT_ALIGN (1)
  ) u0 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid && !sel),
    .req_ready   (rdy0),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .size        (size),
    .is_unsigned (is_unsigned),
    .address     (address),
    .wdata       (wdata),
    .resp_valid  (rv0),
    .rdata       (rd0),
    .invMemAddr  (inv0),
    .fault_valid (fv0),
    .fault_addr  (fa0),
    .fault_cause (fc0),
    .fault_clear (fault_clear && !sel)
  );

  mem_access_unit #(
    .LATENCY      (1),
    .STRICT_ALIGN (0)
  ) u1 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid && sel),
    .req_ready   (rdy1),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .size        (size),
    .is_unsigned (is_unsigned),
    .address     (address),
    .wdata       (wdata),
    .resp_valid  (rv1),
    .rdata       (rd1),
    .invMemAddr  (inv1),
    .fault_valid (fv1),
    .fault_addr  (fa1),
    .fault_cause (fc1),
    .fault_clear (fault_clear && sel)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xact(string tag, bit s, bit rd, bit wr,
                      logic [1:0] sz, bit uns,
                      logic [63:0] a, logic [63:0] wd,
                      logic [63:0] er, bit ei, int el,
                      bit clr = 1'b0);
    int n;
    bit got;
    logic [63:0] e_rd;
    bit e_inv;
    int e_lat;
    q_rd.push_back(er);
    q_inv.push_back(ei);
    q_lat.push_back(el);
    @(negedge clk);
    sel = s;
    MemRead = rd;
    MemWrite = wr;
    size = sz;
    is_unsigned = uns;
    address = a;
    wdata = wd;
    fault_clear = clr;
    req_valid = 1'b1;
    chk({tag, ".rdy"}, {63'd0, sel ? rdy1 : rdy0}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    fault_clear = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 8 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (s_rv) begin
        got = 1'b1;
        e_rd = q_rd.pop_front();
        e_inv = q_inv.pop_front();
        e_lat = q_lat.pop_front();
        chk({tag, ".rdata"}, s_rd, e_rd);
        chk({tag, ".inv"}, {63'd0, s_inv}, {63'd0, e_inv});
        chk({tag, ".lat"}, 64'(n), 64'(e_lat));
      end
    end
    if (!got) begin
      chk({tag, ".timeout"}, 64'd0, 64'd1);
      void'(q_rd.pop_front());
      void'(q_inv.pop_front());
      void'(q_lat.pop_front());
    end
  endtask

  task automatic pulse_clear(bit s);
    @(negedge clk);
    sel = s;
    fault_clear = 1'b1;
    @(posedge clk);
    #1;
    fault_clear = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.ready", {63'd0, rdy0}, 64'd1);
    chk("rst.resp", {63'd0, rv0}, 64'd0);
    chk("rst.rdata", rd0, 64'd0);
    chk("rst.inv", {63'd0, inv0}, 64'd0);
    chk("rst.fv", {63'd0, fv0}, 64'd0);
    chk("rst.fa", fa0, 64'd0);
    chk("rst.fc", {61'd0, fc0}, 64'd0);

    xact("stD", 0, 0, 1, SZ_D, 0, 64'h10, 64'h1122334455667788, 64'd0, 0, 2);
    xact("ldD", 0, 1, 0, SZ_D, 0, 64'h10, 64'd0, 64'h1122334455667788, 0, 2);
    xact("ldBs", 0, 1, 0, SZ_B, 0, 64'h17, 64'd0, 64'h11, 0, 2);
    xact("ldBu", 0, 1, 0, SZ_B, 1, 64'h17, 64'd0, 64'h11, 0, 2);
    xact("ldH", 0, 1, 0, SZ_H, 0, 64'h10, 64'd0, 64'h7788, 0, 2);
    xact("stB", 0, 0, 1, SZ_B, 0, 64'h11, 64'hF0, 64'd0, 0, 2);
    xact("ldBneg", 0, 1, 0, SZ_B, 0, 64'h11, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 2);
    xact("ldDmix", 0, 1, 0, SZ_D, 0, 64'h10, 64'd0, 64'h1122334455667088 | 64'h8000, 0, 2);
    xact("ldHs", 0, 1, 0, SZ_H, 0, 64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_F088, 0, 2);
    xact("ldHu", 0, 1, 0, SZ_H, 1, 64'h10, 64'd0, 64'h0000_0000_0000_F088, 0, 2);
    xact("ldWs", 0, 1, 0, SZ_W, 0, 64'h14, 64'd0, 64'h11223344, 0, 2);
    xact("nop", 0, 0, 0, SZ_D, 0, 64'd8192, 64'd0, 64'd0, 0, 2);
    chk("nop.fv", {63'd0, fv0}, 64'd0);

    xact("stLast", 0, 0, 1, SZ_D, 0, 64'h1FF8, 64'hCAFE_F00D, 64'd0, 0, 2);
    xact("ldLast", 0, 1, 0, SZ_D, 0, 64'h1FF8, 64'd0, 64'hCAFE_F00D, 0, 2);

    xact("oor", 0, 1, 0, SZ_D, 0, 64'd8192, 64'd0, 64'd0, 1, 1);
    chk("oor.fv", {63'd0, fv0}, 64'd1);
    chk("oor.fa", fa0, 64'd8192);
    chk("oor.fc", {61'd0, fc0}, 64'd2);
    xact("hibit", 0, 1, 0, SZ_D, 0, 64'h1_0000_0010, 64'd0, 64'd0, 1, 1);
    xact("mis3", 0, 1, 0, SZ_W, 0, 64'h3, 64'd0, 64'd0, 1, 1);
    chk("sticky.fa", fa0, 64'd8192);
    chk("sticky.fc", {61'd0, fc0}, 64'd2);
    pulse_clear(0);
    chk("clr.fv", {63'd0, fv0}, 64'd0);

    xact("st0", 0, 0, 1, SZ_D, 0, 64'h0, 64'd0, 64'd0, 0, 2);
    xact("stW2", 0, 0, 1, SZ_W, 0, 64'h2, 64'hDEADBEEF, 64'd0, 1, 1);
    chk("stW2.fc", {61'd0, fc0}, 64'd1);
    chk("stW2.fa", fa0, 64'h2);
    xact("ld0", 0, 1, 0, SZ_D, 0, 64'h0, 64'd0, 64'd0, 0, 2);
    pulse_clear(0);

    xact("r.st0", 1, 0, 1, SZ_D, 0, 64'h0, 64'd0, 64'd0, 0, 1);
    xact("r.stW2", 1, 0, 1, SZ_W, 0, 64'h2, 64'hDEADBEEF, 64'd0, 0, 1);
    xact("r.ld0", 1, 1, 0, SZ_D, 0, 64'h0, 64'd0, 64'h0000_DEAD_BEEF_0000, 0, 1);
    xact("r.stW6", 1, 0, 1, SZ_W, 0, 64'h6, 64'h12345678, 64'd0, 1, 1);
    chk("r.fc", {61'd0, fc1}, 64'd1);
    chk("r.fa", fa1, 64'h6);
    xact("r.ld0b", 1, 1, 0, SZ_D, 0, 64'h0, 64'd0, 64'h0000_DEAD_BEEF_0000, 0, 1);

    xact("oor2", 0, 1, 0, SZ_D, 0, 64'd8192, 64'd0, 64'd0, 1, 1);
    xact("rw", 0, 1, 1, SZ_D, 0, 64'h7FF8, 64'd0, 64'd0, 1, 1, 1'b1);
    chk("rw.fv", {63'd0, fv0}, 64'd1);
    chk("rw.fa", fa0, 64'h7FF8);
    chk("rw.fc", {61'd0, fc0}, 64'd6);

    xact("pre20", 0, 0, 1, SZ_D, 0, 64'h20, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 0, 2);
    @(negedge clk);
    sel = 1'b0;
    MemWrite = 1'b1;
    size = SZ_D;
    address = 64'h20;
    wdata = 64'h5555_6666_7777_8888;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    seen = rv0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2.ready", {63'd0, rdy0}, 64'd1);
    chk("rst2.fv", {63'd0, fv0}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      seen |= rv0;
      @(posedge clk);
      #1;
    end
    chk("rst2.noresp", {63'd0, seen}, 64'd0);
    xact("ld20", 0, 1, 0, SZ_D, 0, 64'h20, 64'd0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
